layer_mac_seq: RTL

Parametrised successor to the fully-parallel layer: one fully-connected NN layer computing out[r] = sum_c(values[c]*W[r][c]) + B[r] for all rows, using ROWS MACs that step through one column per clock.
- Weights and biases live in an internal register file, written through an addressed port.
- A start/busy/done handshake sequences the computation.
- Sits between layer instances in the block_temp_inference pipeline; its done pulse chains to the next layer's start.

---
 rtl/layer_mac_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/layer_mac_seq.sv
// Fully-connected NN layer: ROWS parallel MACs step through one input column per clock.
// Define LAYER_MAC_SEQ_RELU_EN to clamp negative row results to zero in the output stage.
module layer_mac_seq #(
    parameter int LAYER_NO   = 0,
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 3,
    parameter int DATAWIDTH  = 4,
    parameter int ACC_W      = 2*DATAWIDTH + $clog2(COLUMNS) + 1,
    localparam int RAW       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CAW       = $clog2(COLUMNS)
) (
    input  logic                         clk,
    input  logic                         rst_overall_n,
    input  logic                         clr,
    input  logic                         start,
    input  logic [COLUMNS*DATAWIDTH-1:0] values,
    input  logic                         wr_en,
    input  logic                         wr_is_bias,
    input  logic [RAW-1:0]               wr_row,
    input  logic [CAW-1:0]               wr_col,
    input  logic [2*DATAWIDTH-1:0]       wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         wr_err,
    output logic [ROWS*ACC_W-1:0]        out
);

    localparam int DW = DATAWIDTH;
    localparam int BW = 2*DATAWIDTH;

    if (ROWS < 1 || COLUMNS < 2 || DATAWIDTH < 1 || LAYER_NO < 0 ||
        ACC_W != 2*DATAWIDTH + $clog2(COLUMNS) + 1) begin : g_param_check
        $error("layer_mac_seq: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_BIAS = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    wr_err_q;
    logic [CAW-1:0]          col_q;
    logic signed [DW-1:0]    vals_q [COLUMNS];
    logic signed [DW-1:0]    w_q    [ROWS][COLUMNS];
    logic signed [BW-1:0]    b_q    [ROWS];
    logic signed [ACC_W-1:0] acc_q  [ROWS];
    logic signed [ACC_W-1:0] out_q  [ROWS];

    // A write landing on the same edge as an accepted start is parked here and
    // committed when the computation ends, so that computation sees the old value.
    logic                    pend_q;
    logic                    pend_bias_q;
    logic [RAW-1:0]          pend_row_q;
    logic [CAW-1:0]          pend_col_q;
    logic [BW-1:0]           pend_data_q;

    logic signed [ACC_W-1:0] acc_d [ROWS];
    logic signed [ACC_W-1:0] res_d [ROWS];

    logic           idle;
    logic           last_col;
    logic           wr_addr_ok;
    logic           wr_ok;
    logic           start_ok;
    logic           commit;
    logic           do_wr;
    logic           wsel_bias;
    logic [RAW-1:0] wsel_row;
    logic [CAW-1:0] wsel_col;
    logic [BW-1:0]  wsel_data;

    assign idle       = (state_q == S_IDLE);
    assign last_col   = (int'(col_q) == COLUMNS - 1);
    assign wr_addr_ok = (int'(wr_row) < ROWS) && (wr_is_bias || (int'(wr_col) < COLUMNS));
    assign wr_ok      = wr_en && idle && wr_addr_ok;
    assign start_ok   = idle && start && !clr;
    assign commit     = pend_q && (clr || (state_q == S_BIAS));
    assign do_wr      = (wr_ok && !start_ok) || commit;

    assign wsel_bias  = commit ? pend_bias_q : wr_is_bias;
    assign wsel_row   = commit ? pend_row_q  : wr_row;
    assign wsel_col   = commit ? pend_col_q  : wr_col;
    assign wsel_data  = commit ? pend_data_q : wr_data;

    genvar gi;
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        logic signed [ACC_W-1:0] prod;
        logic signed [ACC_W-1:0] sum;

        assign prod      = ACC_W'(vals_q[col_q]) * ACC_W'(w_q[gi][col_q]);
        assign acc_d[gi] = acc_q[gi] + prod;
        assign sum       = acc_q[gi] + ACC_W'(b_q[gi]);
`ifdef LAYER_MAC_SEQ_RELU_EN
        assign res_d[gi] = sum[ACC_W-1] ? '0 : sum;
`else
        assign res_d[gi] = sum;
`endif
        assign out[(ROWS-1-gi)*ACC_W +: ACC_W] = out_q[gi];
    end

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_err_q    <= 1'b0;
            col_q       <= '0;
            pend_q      <= 1'b0;
            pend_bias_q <= 1'b0;
            pend_row_q  <= '0;
            pend_col_q  <= '0;
            pend_data_q <= '0;
            for (int c = 0; c < COLUMNS; c++) begin
                vals_q[c] <= '0;
            end
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
                out_q[r] <= '0;
                b_q[r]   <= '0;
                for (int c = 0; c < COLUMNS; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            done_q   <= 1'b0;
            wr_err_q <= wr_en && !(idle && wr_addr_ok);

            if (do_wr) begin
                if (wsel_bias) begin
                    b_q[wsel_row] <= wsel_data;
                end else begin
                    w_q[wsel_row][wsel_col] <= wsel_data[DW-1:0];
                end
            end

            if (wr_ok && start_ok) begin
                pend_q      <= 1'b1;
                pend_bias_q <= wr_is_bias;
                pend_row_q  <= wr_row;
                pend_col_q  <= wr_col;
                pend_data_q <= wr_data;
            end else if (commit) begin
                pend_q <= 1'b0;
            end

            if (clr) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                col_q   <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    acc_q[r] <= '0;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            for (int c = 0; c < COLUMNS; c++) begin
                                vals_q[c] <= values[(COLUMNS-1-c)*DW +: DW];
                            end
                            for (int r = 0; r < ROWS; r++) begin
                                acc_q[r] <= '0;
                            end
                            col_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        for (int r = 0; r < ROWS; r++) begin
                            acc_q[r] <= acc_d[r];
                        end
                        if (last_col) begin
                            col_q   <= '0;
                            state_q <= S_BIAS;
                        end else begin
                            col_q <= col_q + CAW'(1);
                        end
                    end
                    S_BIAS: begin
                        for (int r = 0; r < ROWS; r++) begin
                            out_q[r] <= res_d[r];
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_err = wr_err_q;

endmodule
